// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake and ALU drive bus for alu_issue_ctrl.
// slave = the sequencer; master = the requester plus the ALU it drives.
interface alu_issue_ctrl_if #(
    parameter int N = 64
);
    logic         req_valid;
    logic         req_ready;
    logic [10:0]  req_opcode;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_ctrl;
    logic [N-1:0] alu_result;
    logic         alu_zero;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic         rsp_zero;
    logic         rsp_err;

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, rsp_ready, alu_result, alu_zero,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, alu_a, alu_b, alu_ctrl
    );

    modport master (
        output req_valid, req_opcode, req_a, req_b, rsp_ready, alu_result, alu_zero,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Sequencer that decodes a LEGv8 opcode, drives the ALU for one cycle and
// returns the captured result over a valid/ready response channel.
module alu_issue_ctrl #(
    parameter int N  = 64,
    parameter int CW = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_issue_ctrl_if.slave     bus,
    output logic [CW-1:0]       ops_done,
    output logic [CW-1:0]       err_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0]    CTRL_IDLE = 4'b1111;
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    state_t        state_reg;
    logic [N-1:0]  alu_a_reg;
    logic [N-1:0]  alu_b_reg;
    logic [3:0]    alu_ctrl_reg;
    logic [N-1:0]  rsp_result_reg;
    logic          rsp_zero_reg;
    logic          rsp_err_reg;
    logic [CW-1:0] ops_done_reg;
    logic [CW-1:0] err_count_reg;
    logic [4:0]    dec_next;

    // {legal, alu control code}
    function automatic logic [4:0] decode(input logic [10:0] op);
        casez (op)
            11'b10001011000: decode = 5'b1_0010;  // ADD
            11'b11001011000: decode = 5'b1_0110;  // SUB
            11'b10001010000: decode = 5'b1_0000;  // AND
            11'b10101010000: decode = 5'b1_0001;  // ORR
            11'b11111000010: decode = 5'b1_0010;  // LDUR
            11'b11111000000: decode = 5'b1_0010;  // STUR
            11'b10110100???: decode = 5'b1_0111;  // CBZ
            default:         decode = 5'b0_1111;
        endcase
    endfunction

    assign dec_next = decode(bus.req_opcode);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_ctrl_reg   <= CTRL_IDLE;
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
            rsp_err_reg    <= 1'b0;
            ops_done_reg   <= '0;
            err_count_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (dec_next[4]) begin
                            alu_a_reg    <= bus.req_a;
                            alu_b_reg    <= bus.req_b;
                            alu_ctrl_reg <= dec_next[3:0];
                            state_reg    <= EXEC;
                        end else begin
                            // Undecodable: answer straight away without touching the ALU.
                            alu_ctrl_reg   <= CTRL_IDLE;
                            rsp_result_reg <= '0;
                            rsp_zero_reg   <= 1'b0;
                            rsp_err_reg    <= 1'b1;
                            state_reg      <= RESP;
                        end
                    end
                end
                EXEC: begin
                    rsp_result_reg <= bus.alu_result;
                    rsp_zero_reg   <= bus.alu_zero;
                    rsp_err_reg    <= 1'b0;
                    alu_ctrl_reg   <= CTRL_IDLE;
                    state_reg      <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_reg <= IDLE;
                        if (ops_done_reg != CNT_MAX) ops_done_reg <= ops_done_reg + CNT_ONE;
                        if (rsp_err_reg && (err_count_reg != CNT_MAX))
                            err_count_reg <= err_count_reg + CNT_ONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_reg == IDLE);
    assign bus.rsp_valid  = (state_reg == RESP);
    assign bus.rsp_result = rsp_result_reg;
    assign bus.rsp_zero   = rsp_zero_reg;
    assign bus.rsp_err    = rsp_err_reg;
    assign bus.alu_a      = alu_a_reg;
    assign bus.alu_b      = alu_b_reg;
    assign bus.alu_ctrl   = alu_ctrl_reg;
    assign ops_done       = ops_done_reg;
    assign err_count      = err_count_reg;
endmodule
